// File: rtl/regfile_sb_pkg.sv
// regfile_pkg: shared types, default sizes and read-address extraction for regfile_sb
package regfile_pkg;

    typedef enum logic {INIT, RUN} rf_state_e;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NREGS      = 32;
    localparam int MAX_ADDR_BUS_W = 64;

    function automatic logic [15:0] port_idx(input logic [MAX_ADDR_BUS_W-1:0] bus, input int p, input int aw);
        logic [MAX_ADDR_BUS_W-1:0] m;
        m = (MAX_ADDR_BUS_W'(1) << aw) - MAX_ADDR_BUS_W'(1);
        return 16'((bus >> (p * aw)) & m);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register file
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NUM_RD = 2
);
    localparam int ADDR_W = $clog2(NREGS);

    logic                     init_done;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;

    modport master (
        input  init_done, rd_data, rd_busy,
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr
    );

    modport slave (
        output init_done, rd_data, rd_busy,
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr
    );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; a new producer beats a same-cycle retire
module regfile_scoreboard #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [NREGS-1:0]  busy
);
    // clear first, then set, so issue wins over writeback on the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read register file with zero sweep, scoreboard and optional bypass (REGFILE_BYPASS_EN)
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NREGS   = DEF_NREGS,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam bit Z0     = ZERO_R0 != 0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP    = 1'b1;
`else
    localparam bit BYP    = 1'b0;
`endif

    rf_state_e         state, state_n;
    logic [ADDR_W:0]   cnt, cnt_n;
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              run, we, iss;

    assign run = state == RUN;
    assign we  = run && bus.wr_en && !(Z0 && bus.wr_addr == '0);
    assign iss = run && bus.issue_en && !(Z0 && bus.issue_addr == '0);
    assign bus.init_done = run;

    // sweep state register; reset restarts the zero sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // advance the sweep and leave INIT once the counter reaches NREGS
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == INIT) begin
            cnt_n   = cnt + (ADDR_W+1)'(1);
            state_n = cnt_n == (ADDR_W+1)'(NREGS) ? RUN : INIT;
        end
    end

    // storage: sweep zeros during INIT, writeback during RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) regs[cnt[ADDR_W-1:0]] <= '0;
            else if (we) regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss),
        .set_addr (bus.issue_addr),
        .clr_en   (we),
        .clr_addr (bus.wr_addr),
        .busy     (busy)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              live, hit;
        assign a    = ADDR_W'(port_idx(MAX_ADDR_BUS_W'(bus.rd_addr), p, ADDR_W));
        assign live = run && !(Z0 && a == '0);
        assign hit  = BYP && we && bus.wr_addr == a;
        assign bus.rd_data[p*DATA_W +: DATA_W] = !live ? '0 : hit ? bus.wr_data : regs[a];
        assign bus.rd_busy[p] = live && !hit && busy[a];
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file with an integrated scoreboard for the pipelined core.
- Adds four things to the single-write register file: sequential zero-initialisation after reset, write-to-read bypass, per-register busy (pending-write) tracking, and a configurable number of read ports.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NREGS), register index width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)
ZERO_R0, 0, 1 = register 0 reads 0 always, writes/issues to it ignored

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
init_done  out  1  high once zero-sweep complete
rd_addr  in  NUM_RD*ADDR_W  packed read indices, port p at [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  register has an outstanding producer
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback value
issue_en  in  1  mark issue_addr busy (instruction issued that will write it)
issue_addr  in  ADDR_W  destination of issued instruction

Behaviour:
- FSM states: INIT, RUN. rst (sampled at posedge) -> INIT, sweep counter=0, all busy bits=0, init_done=0.
- INIT: each cycle writes 0 to registers[cnt], cnt++. After the cycle writing NREGS-1 -> RUN. Exactly NREGS cycles after rst deasserts, init_done=1.
- During INIT: wr_en and issue_en ignored. rd_data=0, rd_busy=0.
- rst asserted mid-INIT or in RUN restarts the sweep from 0 and clears busy. Register contents are undefined until the sweep rewrites them.
- RUN write: wr_en -> registers[wr_addr] <= wr_data at posedge, and busy[wr_addr] <= 0.
- RUN issue: issue_en -> busy[issue_addr] <= 1.
- Simultaneous issue and write to the same address: busy ends 1 (new producer wins); data is still written.
- Issue to an already-busy register (WAW): busy stays 1; no error.
- Reads are combinational, zero latency: rd_data[p] = registers[rd_addr[p]].
- Bypass: if wr_en & RUN & wr_addr==rd_addr[p], then rd_data[p]=wr_data and rd_busy[p]=0 in the same cycle. Otherwise rd_busy[p]=busy[rd_addr[p]].
- ZERO_R0=1: address 0 always reads 0, rd_busy 0. Writes and issues to 0 are dropped, including their bypass.
- Index arithmetic: sweep counter ADDR_W+1 bits to detect NREGS without wrap.
- Output reset values: init_done=0, rd_busy=0, rd_data=0 (held by INIT gating).

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read bypass as above.
- Undefined: reads always return stored (pre-write) contents, and rd_busy[p]=busy[rd_addr[p]] unmasked by a same-cycle write. The new value and busy=0 become visible the cycle after the write.

Decomposition:
- Package regfile_pkg holds state enum (INIT, RUN), default DATA_W/NREGS constants, and a function extracting port p from the packed address bus.
- One sub-module, regfile_scoreboard: busy vector with set/clear/priority rules and clear-on-reset. The top keeps storage, the sweep FSM and read muxes.

Test Plan:
- Reset release, NREGS=32 -> init_done low for 32 cycles, high on cycle 32. All 32 registers read 0 afterwards; wr_en pulsed during INIT leaves no effect.
- RUN: write r5=0xDEADBEEF; next cycle rd_addr[0]=5 -> rd_data 0xDEADBEEF. With bypass, same-cycle read also returns 0xDEADBEEF; without bypass it returns 0 that cycle.
- Issue r7 -> rd_busy=1 next cycle. Write r7=0x12 -> busy clears, with bypass rd_busy=0 in the write cycle. Issue and write r7 together -> busy stays 1.
- Both ports read the same register (r3=0x55) and different registers (r3, r9=0xAA) -> correct independent data.
- ZERO_R0=1: write r0=0xFFFFFFFF and issue r0 -> reads 0, rd_busy 0.
- rst pulsed in RUN with r4 busy -> busy cleared, init_done drops, full 32-cycle sweep repeats, r4 reads 0.
